// File: rtl/fifo_pack_wr.sv
// fifo_pack_wr: packs PACK_NUM narrow upstream words into one wide FIFO word.
// Slot 0 holds the first word (LSBs). A word closes either when its last slot
// fills or when in_last is seen; unfilled upper slots are zero-padded.
// The closed word sits in a one-entry output buffer (obuf/ovld) that drives
// the FIFO push/full interface, so push and data_out never depend
// combinationally on in_valid or in_data.
//
// Handshake: a narrow beat transfers on a rising edge where in_valid and
// in_ready are both 1; in_valid/in_data/in_last are don't-care otherwise.
// Downstream, a packed word is written on every edge where push is 1, and
// push is only raised while full is 0.
module fifo_pack_wr #(
    parameter int IN_WIDTH   = 8,
    parameter int PACK_NUM   = 8,
    parameter int DATA_WIDTH = IN_WIDTH * PACK_NUM,
    parameter int CNT_WIDTH  = $clog2(PACK_NUM)
) (
    input  logic                  clk,
    input  logic                  Reset,
    input  logic                  in_valid,
    input  logic [IN_WIDTH-1:0]   in_data,
    input  logic                  in_last,
    output logic                  in_ready,
    output logic                  push,
    output logic [DATA_WIDTH-1:0] data_out,
    input  logic                  full,
    output logic [CNT_WIDTH-1:0]  slot_cnt,
    output logic                  busy
);

    logic [DATA_WIDTH-1:0] acc;
    logic [DATA_WIDTH-1:0] obuf;
    logic                  ovld;
    logic [DATA_WIDTH-1:0] merged;
    logic                  accept;
    logic                  complete;

    // Output side: the buffered word drains whenever the FIFO has room.
    assign data_out = obuf;
    assign push     = ovld && !full && !Reset;
    assign in_ready = (!ovld || !full) && !Reset;
    assign busy     = (slot_cnt != '0) || ovld;

    assign accept   = in_valid && in_ready;
    assign complete = accept && ((slot_cnt == CNT_WIDTH'(PACK_NUM - 1)) || in_last);

    // Accumulator with the incoming beat dropped into its slot; slots above it are zero.
    always_comb begin
        merged = '0;
        for (int i = 0; i < PACK_NUM; i++) begin
            if (CNT_WIDTH'(i) < slot_cnt) begin
                merged[i*IN_WIDTH +: IN_WIDTH] = acc[i*IN_WIDTH +: IN_WIDTH];
            end else if (CNT_WIDTH'(i) == slot_cnt) begin
                merged[i*IN_WIDTH +: IN_WIDTH] = in_data;
            end
        end
    end

    // Accumulator and slot counter: fill on accepted beats, clear on completion.
    always_ff @(posedge clk) begin
        if (Reset) begin
            acc      <= '0;
            slot_cnt <= '0;
        end else if (complete) begin
            acc      <= '0;
            slot_cnt <= '0;
        end else if (accept) begin
            acc      <= merged;
            slot_cnt <= slot_cnt + 1'b1;
        end
    end

    // Output buffer: reload on completion (even while pushing), else clear once pushed.
    always_ff @(posedge clk) begin
        if (Reset) begin
            obuf <= '0;
            ovld <= 1'b0;
        end else if (complete) begin
            obuf <= merged;
            ovld <= 1'b1;
        end else if (push) begin
            ovld <= 1'b0;
        end
    end

endmodule

// File: doc/fifo_pack_wr.md
Name: fifo_pack_wr

Overview:
- Write-side packer that sits directly upstream of the PEB multi-read FIFO.
- Accepts narrow words from the global-buffer read path over a valid/ready handshake.
- Packs PACK_NUM narrow words into one DATA_WIDTH FIFO word, then drives the FIFO push/full interface.
- Handles partial words at end of stream: the unfilled slots are zero-padded.

Parameters:
- IN_WIDTH, 8, width of one incoming narrow word.
- PACK_NUM, 8, narrow words per packed FIFO word (must be ≥2).
- DATA_WIDTH, IN_WIDTH*PACK_NUM (64), packed word width; must match the FIFO data width.
- CNT_WIDTH, clog2(PACK_NUM) (3), width of the slot counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- Reset  in  1  synchronous, active-high reset.
- in_valid  in  1  upstream narrow word valid.
- in_data  in  IN_WIDTH  upstream narrow word.
- in_last  in  1  marks the final narrow word of a stream; closes the current packed word.
- in_ready  out  1  block can accept a narrow word this cycle.
- push  out  1  FIFO write strobe.
- data_out  out  DATA_WIDTH  packed word presented to the FIFO data_in.
- full  in  1  FIFO full (the shared full of the multi-read FIFO).
- slot_cnt  out  CNT_WIDTH  number of narrow words currently held in the accumulator.
- busy  out  1  accumulator or output buffer holds data.

Behaviour:
- State elements:
  - acc[DATA_WIDTH]: accumulator.
  - slot_cnt: next free slot, range 0..PACK_NUM-1.
  - obuf[DATA_WIDTH] with flag ovld: output buffer.
- Reset (at the clk edge with Reset=1): acc=0, slot_cnt=0, obuf=0, ovld=0.
- Outputs during the Reset cycle: push=0, in_ready=0. Both are gated by !Reset.
- Reset has priority over every other event. A partially packed word is discarded. An obuf word not yet pushed is discarded.
- Output assignments:
  - data_out = obuf.
  - push = ovld && !full && !Reset (combinational).
  - in_ready = (!ovld || !full) && !Reset.
  - busy = (slot_cnt!=0) || ovld.
- Accept: a beat is accepted when in_valid && in_ready.
- Slot placement: accepted in_data goes to slice [IN_WIDTH*slot_cnt +: IN_WIDTH]. Slot 0 is the LSBs (first word lowest).
- Completion occurs when an accepted beat has slot_cnt==PACK_NUM-1 or in_last=1.
- On completion, at the same edge:
  - obuf is loaded with acc, with the new beat merged in its slot and all higher slots forced to 0.
  - ovld=1.
  - acc=0, slot_cnt=0.
- On a non-completing accepted beat: acc slice written, slot_cnt+1.
- Latency: completion at edge t gives push=1 in the cycle after t (if full=0). There is no further delay.
- Clearing obuf: when push=1 and no completion occurs at that edge, ovld is cleared.
- Simultaneous push and completion: obuf reloads, ovld stays 1. This sustains back-to-back packed words with no bubble.
- Throughput: one narrow beat per cycle while full=0. One packed word per PACK_NUM cycles.
- Backpressure: with ovld=1 and full=1:
  - push=0, obuf held, in_ready=0.
  - acc and slot_cnt hold.
  - in_data is ignored.
- Single-beat stream: in_last on a beat at slot_cnt=0 yields obuf = {zeros, in_data}.
- in_last at slot_cnt=PACK_NUM-1: identical to normal completion; no extra word is produced.
- in_last with in_valid=0: ignored.
- Empty stream: nothing is ever pushed for a stream with zero accepted beats.
- Wrap-around: slot_cnt returns to 0 after every completion and never reaches PACK_NUM.
- No combinational path from in_valid or in_data to push or data_out.

Test Plan:
- Basic pack (IN_WIDTH=8, PACK_NUM=8), full=0:
  - Stimulus: beats 0x01..0x08 on consecutive cycles.
  - Required: one push, one cycle after the 8th accept, with data_out=0x0807060504030201; slot_cnt steps 0..7 then back to 0.
- Partial + pad:
  - Stimulus: beats 0xA1, 0xA2, 0xA3 with in_last on 0xA3.
  - Required: push with data_out=0x0000000000A3A2A1; slot_cnt=0 and busy=0 after the push.
- Backpressure:
  - Stimulus: complete a word with full=1 for 4 cycles, then full=0.
  - Required: push=0, in_ready=0 and data_out stable for those 4 cycles; push=1 for exactly one cycle on release.
- Streaming:
  - Stimulus: 16 back-to-back beats 0x10..0x1F, full=0.
  - Required: in_ready=1 throughout; two pushes, 8 cycles apart:
    - 0x1716151413121110
    - 0x1F1E1D1C1B1A1918
- Reset mid-operation:
  - Stimulus: 5 beats accepted, then Reset=1 for 1 cycle, then beats 0x21..0x28.
  - Required: push=0 during reset; the single word pushed afterward is 0x2827262524232221 (no stale data).
- Single-beat last while blocked:
  - Stimulus: ovld=1 and full=1, in_valid=1 with in_last=1 and in_data=0x5A.
  - Required: beat not accepted until full=0; then two consecutive pushes, the old word followed by 0x000000000000005A.
